// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants, counter FSM states and frame-size helpers for the SIPO receiver
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {COLLECT, LAST} cnt_state_t;

    function automatic int fl(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg: one-word output holding register with valid/ready handshake and sticky overrun
module sipo_hold_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             parity_err
);

    logic take;

    assign take = load && (!data_valid || data_ready);

    // capture completed words when there is room, otherwise flag the drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (take) begin
                data_out   <= load_data;
                parity_err <= load_perr;
            end
            data_valid <= take ? 1'b1 : (data_valid && data_ready) ? 1'b0 : data_valid;
            overrun    <= clr ? 1'b0 : (load && !take) ? 1'b1 : overrun;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: MSB-first serial-to-parallel receiver; define SIPO_PARITY_EN for a trailing even-parity bit per frame
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_en,
    input  logic                     serial_in,
    input  logic                     clr,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [cnt_w(WIDTH)-1:0]  bit_cnt,
    output logic                     overrun,
    output logic                     parity_err
);

`ifdef SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] PRE_LAST = CW'(fl(WIDTH, PAR) - 2);

    cnt_state_t st, st_nx;
    logic [CW-1:0] cnt_nx;
    logic [WIDTH-1:0] sr, word;
    logic sample, shift_en, done, perr;

    assign sample = bit_en && !clr;

`ifdef SIPO_PARITY_EN
    assign shift_en = sample && (st == COLLECT);
    assign word     = sr;
    assign perr     = ^{sr, serial_in};
`else
    assign shift_en = sample;
    assign word     = {sr[WIDTH-2:0], serial_in};
    assign perr     = 1'b0;
`endif

    // frame counter FSM: next state, next count and completion strobe
    always_comb begin
        st_nx  = st;
        cnt_nx = bit_cnt;
        done   = 1'b0;
        if (clr) begin
            st_nx  = COLLECT;
            cnt_nx = '0;
        end else if (bit_en) begin
            if (st == LAST) begin
                st_nx  = COLLECT;
                cnt_nx = '0;
                done   = 1'b1;
            end else begin
                st_nx  = (bit_cnt == PRE_LAST) ? LAST : COLLECT;
                cnt_nx = bit_cnt + CW'(1);
            end
        end
    end

    // frame counter FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= COLLECT;
            bit_cnt <= '0;
        end else begin
            st      <= st_nx;
            bit_cnt <= cnt_nx;
        end
    end

    // data shift register, MSB arrives first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[WIDTH-2:0], serial_in};
        end
    end

    sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load       (done),
        .load_data  (word),
        .load_perr  (perr),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed and randomized bench for sipo_rx against a frame-queue reference model
module tb_sipo_rx;

    localparam int W = 32;
`ifdef SIPO_PARITY_EN
    localparam int FL = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL = W;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bit_en = 1'b0;
    logic serial_in = 1'b0;
    logic clr = 1'b0;
    logic data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic data_valid;
    logic [$clog2(W+1)-1:0] bit_cnt;
    logic overrun;
    logic parity_err;

    int n_chk = 0;
    int n_pass = 0;

    bit fq[$];
    logic [W-1:0] m_hold;
    bit m_valid, m_ovr, m_perr;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .clr        (clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        fq.delete();
        m_hold  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge(input bit be, input bit si, input bit cl, input bit rdy);
        bit cons, done, perr;
        logic [W-1:0] w;
        int ones;
        cons = m_valid && rdy;
        done = 1'b0;
        w    = '0;
        perr = 1'b0;
        if (cl) begin
            fq.delete();
            m_ovr = 1'b0;
        end else if (be) begin
            fq.push_back(si);
            if (fq.size() == FL) begin
                done = 1'b1;
                ones = 0;
                for (int i = 0; i < FL; i++) begin
                    if (i < W) w = w * 2 + W'(fq[i]);
                    ones += int'(fq[i]);
                end
                perr = PAR && (ones % 2 == 1);
                fq.delete();
            end
        end
        if (done && (!m_valid || cons)) begin
            m_hold  = w;
            m_valid = 1'b1;
            m_perr  = perr;
        end else begin
            if (done) m_ovr = 1'b1;
            if (cons) m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".data_out"}, 64'(data_out), 64'(m_hold));
        chk({ctx, ".data_valid"}, 64'(data_valid), 64'(m_valid));
        chk({ctx, ".bit_cnt"}, 64'(bit_cnt), 64'(fq.size()));
        chk({ctx, ".overrun"}, 64'(overrun), 64'(m_ovr));
        chk({ctx, ".parity_err"}, 64'(parity_err), 64'(m_perr));
    endtask

    task automatic tick(input bit be, input bit si, input bit cl, input bit rdy);
        bit_en     = be;
        serial_in  = si;
        clr        = cl;
        data_ready = rdy;
        @(posedge clk);
        model_edge(be, si, cl, rdy);
        #1;
        check_all("cyc");
    endtask

    // mode: 0/1 fixed ready, 2 random ready, 3 ready only on the final sample edge
    task automatic send_word(input logic [W-1:0] w, input int gap, input int mode, input bit badp);
        bit b, r;
        for (int i = 0; i < FL; i++) begin
            b = (i < W) ? w[W-1-i] : ((^w) ^ badp);
            r = (mode == 2) ? bit'($urandom_range(0, 1)) : (mode == 3) ? (i == FL - 1) : bit'(mode);
            repeat ($urandom_range(0, gap)) tick(1'b0, bit'($urandom_range(0, 1)), 1'b0, (mode == 3) ? 1'b0 : r);
            tick(1'b1, b, 1'b0, r);
        end
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        #4 rst = 1'b1;

        for (int i = 0; i < 10; i++) tick(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #2 rst = 1'b1;

        send_word(32'hB77BEFDF, 0, 0, 1'b0);
        chk("first_word", 64'(data_out), 64'hB77BEFDF);
        chk("first_valid", 64'(data_valid), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(32'hB77BEFDF, 0, 1, 1'b0);
        send_word(32'h00000001, 0, 1, 1'b0);
        send_word(32'hFFFFFFFF, 0, 1, 1'b0);
        chk("stream_last", 64'(data_out), 64'hFFFFFFFF);
        chk("stream_ovr", 64'(overrun), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(32'h80000001, 5, 1, 1'b0);
        chk("gap_word", 64'(data_out), 64'h80000001);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(32'h12345678, 0, 0, 1'b0);
        send_word(32'h9ABCDEF0, 0, 0, 1'b0);
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_hold", 64'(data_out), 64'h12345678);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_ovr", 64'(overrun), 64'd0);
        chk("clr_hold", 64'(data_out), 64'h12345678);

        send_word(32'hCAFE0042, 0, 3, 1'b0);
        chk("same_edge_valid", 64'(data_valid), 64'd1);
        chk("same_edge_data", 64'(data_out), 64'hCAFE0042);
        chk("same_edge_ovr", 64'(overrun), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 7; i++) tick(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_cnt", 64'(bit_cnt), 64'd0);

        for (int k = 0; k < 8; k++) send_word(W'($urandom), 3, 2, bit'($urandom_range(0, 1)));
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
        send_word(32'hB77BEFDF, 0, 0, 1'b0);
        chk("par_good", 64'(parity_err), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'hB77BEFDF, 0, 0, 1'b1);
        chk("par_bad", 64'(parity_err), 64'd1);
        chk("par_bad_data", 64'(data_out), 64'hB77BEFDF);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
